// File: rtl/seg7_message_player.sv
// Plays a runtime-written string of glyph codes on one 7-segment digit.
// Outputs are registered and change on the edge that enters the new state.
module seg7_message_player #(
    parameter int MSG_LEN      = 16,
    parameter int PRESCALE_W   = 22,
    parameter bit COMMON_ANODE = 1'b1,
    localparam int AW = $clog2(MSG_LEN),
    localparam int LW = $clog2(MSG_LEN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [4:0]    wr_data,
    input  logic [LW-1:0] msg_len,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    input  logic          gap_en,
    output logic [7:0]    seg,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] cur_idx
);

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP, S_DONE} state_t;

    localparam logic [7:0] POL   = {8{COMMON_ANODE}};
    localparam logic [7:0] BLANK = POL;

    function automatic logic [7:0] glyph(input logic [4:0] code);
        logic [7:0] p;
        case (code)
            5'd0:  p = 8'h3F;  5'd1:  p = 8'h06;  5'd2:  p = 8'h5B;  5'd3:  p = 8'h4F;
            5'd4:  p = 8'h66;  5'd5:  p = 8'h6D;  5'd6:  p = 8'h7D;  5'd7:  p = 8'h07;
            5'd8:  p = 8'h7F;  5'd9:  p = 8'h6F;  5'd10: p = 8'h77;  5'd11: p = 8'h7C;
            5'd12: p = 8'h39;  5'd13: p = 8'h5E;  5'd14: p = 8'h79;  5'd15: p = 8'h71;
            5'd16: p = 8'h76;  5'd17: p = 8'h38;  5'd18: p = 8'h73;  5'd19: p = 8'h3E;
            5'd20: p = 8'h40;  5'd21: p = 8'h08;  5'd22: p = 8'h30;  5'd23: p = 8'h54;
            default: p = 8'h00;
        endcase
        return p ^ POL;
    endfunction

    logic [4:0]            mem_q [MSG_LEN];
    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [AW-1:0]         idx_q, idx_d, idx_nx;
    logic [LW-1:0]         len_q, len_d;
    logic [7:0]            seg_q, seg_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic                  tick, last, adv;

    // Message RAM is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    assign tick   = &presc_q;
    assign idx_nx = idx_q + AW'(1);
    assign last   = (LW'(idx_q) == len_q - LW'(1));

    always_comb begin
        state_d = state_q;
        presc_d = presc_q + PRESCALE_W'(1);
        idx_d   = idx_q;
        len_d   = len_q;
        seg_d   = seg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        adv     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                presc_d = '0;
                if (start) begin
                    if (msg_len == '0)              len_d = LW'(1);
                    else if (msg_len > LW'(MSG_LEN)) len_d = LW'(MSG_LEN);
                    else                            len_d = msg_len;
                    state_d = S_SHOW;
                    idx_d   = '0;
                    seg_d   = glyph(mem_q[0]);
                    busy_d  = 1'b1;
                end
            end
            S_SHOW: begin
                if (tick) begin
                    if (gap_en) begin
                        state_d = S_GAP;
                        presc_d = '0;
                        seg_d   = BLANK;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            S_GAP: adv = tick;
            default: state_d = S_IDLE;
        endcase

        if (adv) begin
            presc_d = '0;
            if (!last) begin
                state_d = S_SHOW;
                idx_d   = idx_nx;
                seg_d   = glyph(mem_q[idx_nx]);
            end else if (loop_en) begin
                state_d = S_SHOW;
                idx_d   = '0;
                seg_d   = glyph(mem_q[0]);
            end else begin
                state_d = S_DONE;
                seg_d   = BLANK;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end

        // stop overrides every transition above, including a start in the same cycle
        if (stop) begin
            state_d = S_IDLE;
            presc_d = '0;
            idx_d   = '0;
            seg_d   = BLANK;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            idx_q   <= '0;
            len_q   <= LW'(1);
            seg_q   <= BLANK;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            seg_q   <= seg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign seg     = seg_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cur_idx = idx_q;

endmodule
